// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - NEC decoder states, unit-window constants and window helper
package ir_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LEAD_MARK  = 3'd1,
      LEAD_SPACE = 3'd2,
      BIT_MARK   = 3'd3,
      BIT_SPACE  = 3'd4,
      STOP_MARK  = 3'd5
   } ir_state_t;

   // Accepted phase lengths, in completed 562.5 us units.
   localparam int unsigned LEAD_MARK_MIN  = 12;
   localparam int unsigned LEAD_MARK_MAX  = 20;
   localparam int unsigned LEAD_SPACE_MIN = 6;
   localparam int unsigned LEAD_SPACE_MAX = 10;
   localparam int unsigned BIT_MARK_MAX   = 2;
   localparam int unsigned BIT_ZERO_MAX   = 1;
   localparam int unsigned BIT_ONE_MIN    = 2;
   localparam int unsigned BIT_ONE_MAX    = 4;
   localparam int unsigned STOP_MARK_MAX  = 2;
   localparam int unsigned REPEAT_MIN     = 3;
   localparam int unsigned REPEAT_MAX     = 5;

   function automatic logic in_win(input int unsigned u,
                                   input int unsigned lo,
                                   input int unsigned hi);
      return (u >= lo) && (u <= hi);
   endfunction

endpackage

// File: rtl/ir_unit_timer.sv
// rtl/ir_unit_timer.sv - prescaler plus saturating completed-unit counter with sync clear
module ir_unit_timer #(
   parameter int UNIT_TICKS = 28125,
   parameter int MAX_UNITS  = 25,
   parameter int UW         = $clog2(MAX_UNITS + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   output logic [UW-1:0] unit_cnt
);

   localparam int PW = $clog2(UNIT_TICKS + 1);

   logic [PW-1:0] presc;
   logic [PW-1:0] presc_base;
   logic [UW-1:0] cnt;
   logic [UW-1:0] cnt_base;

   // The clearing cycle is itself tick 0 of the new phase, so a phase of
   // N*UNIT_TICKS cycles reads exactly N at its terminating edge.
   always_comb begin
      presc_base = clear ? '0 : presc;
      cnt_base   = clear ? '0 : cnt;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         presc <= '0;
         cnt   <= '0;
      end else if (presc_base == PW'(UNIT_TICKS - 1)) begin
         presc <= '0;
         if (cnt_base != UW'(MAX_UNITS))
            cnt <= cnt_base + UW'(1);
         else
            cnt <= cnt_base;
      end else begin
         presc <= presc_base + PW'(1);
         cnt   <= cnt_base;
      end
   end

   assign unit_cnt = cnt;

endmodule

// File: rtl/ir_pulse_decoder.sv
// rtl/ir_pulse_decoder.sv - NEC IR line to serial bits + strobes; NEC_REPEAT_EN adds repeat_code
module ir_pulse_decoder
   import ir_pkg::*;
#(
   parameter int UNIT_TICKS    = 28125,
   parameter int N_BITS        = 32,
   parameter int TIMEOUT_UNITS = 24
) (
   input  logic clk,
   input  logic reset,
   input  logic ir_in,
   output logic sin,
   output logic shift_en,
   output logic frame_start,
   output logic frame_done,
   output logic error,
`ifdef NEC_REPEAT_EN
   output logic repeat_code,
`endif
   output logic busy
);

   localparam int UW = $clog2(TIMEOUT_UNITS + 2);
   localparam int BW = $clog2(N_BITS + 1);

   logic          sync1, sync2, prev;
   logic          rise_q, fall_q;
   logic [UW-1:0] unit_cnt;
   int unsigned   u;

   ir_state_t     state, state_n;
   logic [BW-1:0] bit_cnt, bit_cnt_n;
   logic          sin_n, shift_n, start_n, err_n, last_n;
   logic          done_pend;
`ifdef NEC_REPEAT_EN
   logic          rep_n;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         prev   <= 1'b1;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync1  <= ir_in;
         sync2  <= sync1;
         prev   <= sync2;
         rise_q <= sync2 & ~prev;
         fall_q <= ~sync2 & prev;
      end
   end

   ir_unit_timer #(
      .UNIT_TICKS (UNIT_TICKS),
      .MAX_UNITS  (TIMEOUT_UNITS + 1),
      .UW         (UW)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (rise_q | fall_q),
      .unit_cnt (unit_cnt)
   );

   assign u = 32'(unit_cnt);

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      sin_n     = 1'b0;
      shift_n   = 1'b0;
      start_n   = 1'b0;
      err_n     = 1'b0;
      last_n    = 1'b0;
`ifdef NEC_REPEAT_EN
      rep_n     = 1'b0;
`endif
      // A stuck line saturates the unit counter, so every non-idle phase ends here.
      if (state != IDLE && u > TIMEOUT_UNITS) begin
         err_n   = 1'b1;
         state_n = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (fall_q)
                  state_n = LEAD_MARK;
            end
            LEAD_MARK: begin
               if (rise_q) begin
                  if (in_win(u, LEAD_MARK_MIN, LEAD_MARK_MAX)) begin
                     state_n = LEAD_SPACE;
                  end else begin
                     err_n   = 1'b1;
                     state_n = IDLE;
                  end
               end
            end
            LEAD_SPACE: begin
               if (fall_q) begin
                  if (in_win(u, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                     start_n   = 1'b1;
                     bit_cnt_n = '0;
                     state_n   = BIT_MARK;
`ifdef NEC_REPEAT_EN
                  end else if (in_win(u, REPEAT_MIN, REPEAT_MAX)) begin
                     rep_n   = 1'b1;
                     state_n = STOP_MARK;
`endif
                  end else begin
                     err_n   = 1'b1;
                     state_n = IDLE;
                  end
               end
            end
            BIT_MARK: begin
               if (rise_q) begin
                  if (u <= BIT_MARK_MAX) begin
                     state_n = BIT_SPACE;
                  end else begin
                     err_n   = 1'b1;
                     state_n = IDLE;
                  end
               end
            end
            BIT_SPACE: begin
               if (fall_q) begin
                  if (u <= BIT_ZERO_MAX || in_win(u, BIT_ONE_MIN, BIT_ONE_MAX)) begin
                     sin_n     = (u >= BIT_ONE_MIN);
                     shift_n   = 1'b1;
                     bit_cnt_n = bit_cnt + BW'(1);
                     if (bit_cnt == BW'(N_BITS - 1)) begin
                        last_n  = 1'b1;
                        state_n = STOP_MARK;
                     end else begin
                        state_n = BIT_MARK;
                     end
                  end else begin
                     err_n   = 1'b1;
                     state_n = IDLE;
                  end
               end
            end
            STOP_MARK: begin
               if (rise_q) begin
                  err_n   = (u > STOP_MARK_MAX);
                  state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Strobes are registered; frame_done trails the last shift_en by one cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         sin         <= 1'b0;
         shift_en    <= 1'b0;
         frame_start <= 1'b0;
         error       <= 1'b0;
         done_pend   <= 1'b0;
         frame_done  <= 1'b0;
`ifdef NEC_REPEAT_EN
         repeat_code <= 1'b0;
`endif
      end else begin
         state       <= state_n;
         bit_cnt     <= bit_cnt_n;
         sin         <= sin_n;
         shift_en    <= shift_n;
         frame_start <= start_n;
         error       <= err_n;
         done_pend   <= last_n;
         frame_done  <= done_pend;
`ifdef NEC_REPEAT_EN
         repeat_code <= rep_n;
`endif
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_ir_pulse_decoder.sv
// tb/tb_ir_pulse_decoder.sv - scoreboard bench for ir_pulse_decoder (UNIT_TICKS=4, NEC_REPEAT_EN aware)
module tb_ir_pulse_decoder;

   localparam int UT = 4;
   localparam int K_START = 0, K_BIT = 1, K_DONE = 2, K_ERR = 3, K_REP = 4;

   typedef struct {
      int   kind;
      logic b;
   } ev_t;

   logic clk, reset, ir_in;
   logic sin, shift_en, frame_start, frame_done, error, busy, rep;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   int  cyc      = 0;
   int  last_shift_cyc = -100;

   ir_pulse_decoder #(.UNIT_TICKS(UT)) dut (
      .clk         (clk),
      .reset       (reset),
      .ir_in       (ir_in),
      .sin         (sin),
      .shift_en    (shift_en),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .error       (error),
`ifdef NEC_REPEAT_EN
      .repeat_code (rep),
`endif
      .busy        (busy)
   );

`ifndef NEC_REPEAT_EN
   assign rep = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic void check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   function automatic void push(input int k, input logic b = 1'b0);
      ev_t e;
      e.kind = k;
      e.b    = b;
      exp_q.push_back(e);
   endfunction

   // Protocol reference: phases alternate low/high starting with the leader mark,
   // lengths in whole units. Returns how many phases to drive and whether a short
   // mark must follow so the error-causing falling edge is not followed by a new leader.
   function automatic void decode(input int ph[$], output int used, output bit app);
      int n;
      n    = ph.size();
      used = n;
      app  = 1'b0;
      if (ph[0] < 12 || ph[0] > 20) begin push(K_ERR); used = 1; return; end
      if (n < 2) begin push(K_ERR); return; end
      if (ph[1] > 24) begin push(K_ERR); used = 2; return; end
      if (ph[1] >= 6 && ph[1] <= 10) begin
         push(K_START);
         for (int b = 0; b < 32; b++) begin
            int mi, sp;
            mi = 2 + 2 * b;
            if (mi >= n) begin push(K_ERR); used = n; return; end
            if (ph[mi] > 2) begin push(K_ERR); used = mi + 1; return; end
            if (mi + 1 >= n) begin push(K_ERR); used = n; return; end
            sp = ph[mi + 1];
            if (sp > 24) begin push(K_ERR); used = mi + 2; return; end
            if (sp >= 5) begin push(K_ERR); used = mi + 2; app = 1'b1; return; end
            push(K_BIT, sp >= 2);
         end
         push(K_DONE);
         if (n > 66 && ph[66] > 2) push(K_ERR);
         return;
      end
`ifdef NEC_REPEAT_EN
      if (ph[1] >= 3 && ph[1] <= 5) begin
         push(K_REP);
         if (n > 2 && ph[2] > 2) push(K_ERR);
         used = (n > 2) ? 3 : n;
         return;
      end
`endif
      push(K_ERR);
      used = 2;
      app  = 1'b1;
   endfunction

   function automatic void build_frame(input logic [31:0] data, input int lead, input int space,
                                       input bit rnd, output int ph[$]);
      ph = {};
      ph.push_back(lead);
      ph.push_back(space);
      for (int b = 31; b >= 0; b--) begin
         ph.push_back(rnd ? int'($urandom_range(1, 2)) : 1);
         if (data[b])
            ph.push_back(rnd ? int'($urandom_range(2, 4)) : 3);
         else
            ph.push_back(1);
      end
      ph.push_back(1);
   endfunction

   task automatic drive(input logic lvl, input int units);
      ir_in = lvl;
      repeat (units * UT) @(posedge clk);
      #1;
   endtask

   task automatic run_burst(input int ph[$]);
      int used;
      bit app;
      decode(ph, used, app);
      for (int i = 0; i < used; i++)
         drive((i % 2 == 0) ? 1'b0 : 1'b1, ph[i]);
      if (app)
         drive(1'b0, 1);
      drive(1'b1, 30);
      check("queue_drained", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
      check("idle_busy", busy, 0);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      int n, kind;
      ev_t e;
      if (reset) begin
         n = shift_en + frame_start + frame_done + error + rep;
         if (n >= 1) begin
            check("one_strobe_per_cycle", n, 1);
            kind = frame_start ? K_START : shift_en ? K_BIT : frame_done ? K_DONE :
                   error ? K_ERR : K_REP;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_strobe: got kind %0d expected none", kind);
            end else begin
               e = exp_q.pop_front();
               check("strobe_kind", kind, e.kind);
               if (kind == K_BIT && e.kind == K_BIT)
                  check("sin_bit", sin, e.b);
               if (kind == K_DONE)
                  check("done_latency", cyc - last_shift_cyc, 1);
            end
         end
         if (shift_en)
            last_shift_cyc = cyc;
      end
      cyc++;
   end

   initial begin
      int ph[$];
      logic [31:0] d;

      ir_in = 1'b1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_sin", sin, 0);
      check("rst_shift_en", shift_en, 0);
      check("rst_frame_start", frame_start, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_error", error, 0);
      check("rst_busy", busy, 0);
      check("rst_repeat", rep, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      drive(1'b1, 4);

      build_frame(32'h00FF_A55A, 16, 8, 1'b0, ph);
      run_burst(ph);

      ph = {8};
      run_burst(ph);

      ph = {40};
      run_burst(ph);

      build_frame(32'h1234_5678, 16, 8, 1'b0, ph);
      ph[3 + 2 * 5] = 6;
      run_burst(ph);

      ph = {16, 4, 1};
      run_burst(ph);

      // Reset in the middle of a frame, after ten bits.
      d = 32'hC35A_0F96;
      build_frame(d, 16, 8, 1'b0, ph);
      push(K_START);
      for (int b = 0; b < 10; b++)
         push(K_BIT, d[31 - b]);
      for (int i = 0; i < 22; i++)
         drive((i % 2 == 0) ? 1'b0 : 1'b1, ph[i]);
      drive(1'b0, 2);
      @(negedge clk);
      check("busy_before_reset", busy, 1);
      @(posedge clk);
      #1;
      ir_in = 1'b1;
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_busy", busy, 0);
      check("midrst_strobes", shift_en + frame_start + frame_done + error + rep, 0);
      check("midrst_sin", sin, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      drive(1'b1, 30);
      check("midrst_queue", exp_q.size(), 0);
      exp_q.delete();
      build_frame(32'hDEAD_BEEF, 12, 10, 1'b1, ph);
      run_burst(ph);

      // Boundary windows, then randomized frames with occasional corruption.
      build_frame(32'h8000_0001, 20, 6, 1'b1, ph);
      run_burst(ph);
      build_frame(32'h0F0F_F0F0, 11, 8, 1'b0, ph);
      run_burst(ph);
      build_frame(32'h0F0F_F0F0, 21, 8, 1'b0, ph);
      run_burst(ph);
      build_frame(32'hFFFF_0000, 16, 11, 1'b0, ph);
      run_burst(ph);
      build_frame(32'hFFFF_0000, 16, 8, 1'b0, ph);
      ph[2 + 2 * 7] = 3;
      run_burst(ph);
      build_frame(32'hFFFF_FFFF, 16, 8, 1'b0, ph);
      ph[3 + 2 * 31] = 4;
      ph[66] = 2;
      run_burst(ph);
      build_frame(32'h0000_0000, 16, 8, 1'b0, ph);
      ph[66] = 3;
      run_burst(ph);

      for (int f = 0; f < 24; f++) begin
         d = $urandom;
         build_frame(d, $urandom_range(12, 20), $urandom_range(6, 10), 1'b1, ph);
         if ($urandom_range(0, 2) == 0)
            ph[$urandom_range(0, 66)] = $urandom_range(1, 30);
         run_burst(ph);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ir_pulse_decoder.md
Name: ir_pulse_decoder

Overview:
- Front-end of the VCR remote decoder: converts the raw demodulated IR receiver line (NEC protocol) into a serial bit stream plus strobes.
- Feeds the serial-in shift register directly downstream: sin carries the decoded bit, shift_en strobes it in, frame_start clears the register, frame_done flags a complete 32-bit word.

Parameters:
- UNIT_TICKS, 28125, clk cycles per 562.5 us NEC unit (50 MHz clk).
- N_BITS, 32, data bits per frame; must match downstream shift register width.
- TIMEOUT_UNITS, 24, units any single phase may last before abort.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset; asserted when 0 at a clk edge.
- ir_in  in  1  asynchronous IR receiver output; idle high, mark = low.
- sin  out  1  decoded bit; valid in the cycle shift_en=1.
- shift_en  out  1  one-cycle pulse per decoded bit.
- frame_start  out  1  one-cycle pulse when a valid leader is accepted (downstream clears/loads 0).
- frame_done  out  1  one-cycle pulse one cycle after the N_BITS-th shift_en.
- error  out  1  one-cycle pulse on any timing violation or timeout.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0 at edge): state IDLE; all outputs 0; synchronizer flops 1; counters 0. Overrides any in-progress frame; no error pulse is emitted.
- ir_in passes through a 2-flop synchronizer, then a registered edge detector. Edge-to-FSM latency is 3 cycles.
- Unit timer: prescaler counts 0..UNIT_TICKS-1. On wrap, unit_cnt increments, saturating at TIMEOUT_UNITS+1. Both clear on every synchronized edge.
- Each phase is classified at its terminating edge using the completed-unit count u.
- FSM states: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK.
  - IDLE: falling edge -> LEAD_MARK.
  - LEAD_MARK: rising edge with 12<=u<=20 -> LEAD_SPACE, otherwise error -> IDLE.
  - LEAD_SPACE: falling edge with 6<=u<=10 -> pulse frame_start, clear bit_cnt -> BIT_MARK, otherwise error -> IDLE.
  - BIT_MARK: rising edge with u<=2 -> BIT_SPACE, otherwise error -> IDLE.
  - BIT_SPACE: falling edge with u<=1 gives bit 0; 2<=u<=4 gives bit 1; u>=5 gives error -> IDLE.
    - On a valid bit: sin=bit, shift_en=1 for one cycle, bit_cnt++.
    - If bit_cnt reaches N_BITS -> STOP_MARK, with frame_done the following cycle; else -> BIT_MARK.
  - STOP_MARK: rising edge -> IDLE (any u<=2; otherwise error, frame_done already issued).
- Timeout: in any non-IDLE state, u exceeding TIMEOUT_UNITS -> error pulse, -> IDLE. The line stuck low never hangs the FSM.
- Bit order: first received bit shifted first (ends in q MSB downstream).
- Never two strobes in one cycle. frame_start and shift_en cannot coincide: the first shift occurs at least 2 units later.
- bit_cnt width $clog2(N_BITS+1).

Optional Feature:
- Macro NEC_REPEAT_EN.
- Defined: in LEAD_SPACE, falling edge with 3<=u<=5 -> repeat pulse (extra 1-bit output port "repeat") -> STOP_MARK. No frame_start, no shift_en.
- Undefined: no repeat port; that window is an error like any other out-of-range value.

Decomposition:
- Package ir_pkg holds:
  - state enum typedef;
  - unit-window constants (LEAD_MARK_MIN/MAX, LEAD_SPACE_MIN/MAX, BIT_ONE_MIN/MAX, REPEAT_MIN/MAX).
- One sub-module, ir_unit_timer: prescaler plus saturating unit counter with sync clear input and unit count output.
- FSM, synchronizer and edge detect stay in the top module.

Test Plan (sim with UNIT_TICKS=4):
- Reset mid-frame after 10 bits -> all outputs 0 next cycle; a following full frame decodes correctly.
- Valid frame 0x00FF_A55A (16u mark, 8u space, 32 bits, stop) -> 1 frame_start, 32 shift_en with sin matching MSB-first bits, frame_done 1 cycle after the last shift_en, error never high.
- Leader mark of 8u -> error pulse at its rising edge, no frame_start, busy low after.
- ir_in held low 40u -> error once when u>24, FSM in IDLE, no further pulses.
- Bit space of 6u at bit 5 -> error, only 5 shift_en issued, no frame_done.
- With NEC_REPEAT_EN: 16u mark, 4u space, 1u stop -> single repeat pulse, zero shift_en; without the macro the same stimulus gives an error pulse.
